layer4_result_mem_ctrl: RTL and testbench

- Sequencer for the layer-4 result SRAM, a 12x12 feature map stored row-major at address row*12+col.
- Write side: turns the layer-4 result stream into save_enable plus save row/col addresses.
- Read side: generates 3x3 sliding-window tap addresses for layer 5, gated so a window is read only after its rows are fully written.
- Sits between the layer-4 datapath, the result memory and the layer-5 engine; handles one frame per start pulse.

---
 rtl/layer4_result_mem_ctrl_pkg.sv | 16 +
 rtl/layer4_result_mem_ctrl_if.sv | 33 +++
 rtl/layer4_window_addr_gen.sv | 86 ++++++++
 rtl/layer4_result_mem_ctrl.sv | 153 +++++++++++++++
 tb/tb_layer4_result_mem_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/layer4_result_mem_ctrl_pkg.sv
// rtl/layer4_result_mem_ctrl_pkg.sv - shared types and geometry for the layer-4 result memory controller
// Purpose: FSM state type and feature-map / kernel geometry shared by the controller files.
package layer4_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MAP_W = 12;
  localparam int MAP_H = 12;
  localparam int K     = 3;
  localparam int TAPS  = K * K;

endpackage

// File: rtl/layer4_result_mem_ctrl_if.sv
// rtl/layer4_result_mem_ctrl_if.sv - write/read bus between controller, result SRAM and layer 5
// Purpose: groups the write-side and read-side handshake and address signals.
// Ports (master = controller side):
//   in : wr_valid, rd_ready
//   out: save_enable, save_row_addr, save_col_addr, layer4_result_read_signal,
//        read_row_addr, read_col_addr, tap_valid, tap_idx, window_last
interface layer4_result_mem_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              wr_valid;
  logic              save_enable;
  logic [ADDR_W-1:0] save_row_addr;
  logic [ADDR_W-1:0] save_col_addr;
  logic              rd_ready;
  logic              layer4_result_read_signal;
  logic [ADDR_W-1:0] read_row_addr;
  logic [ADDR_W-1:0] read_col_addr;
  logic              tap_valid;
  logic [3:0]        tap_idx;
  logic              window_last;

  modport master (
    input  wr_valid, rd_ready,
    output save_enable, save_row_addr, save_col_addr, layer4_result_read_signal,
           read_row_addr, read_col_addr, tap_valid, tap_idx, window_last
  );

  modport slave (
    output wr_valid, rd_ready,
    input  save_enable, save_row_addr, save_col_addr, layer4_result_read_signal,
           read_row_addr, read_col_addr, tap_valid, tap_idx, window_last
  );
endinterface

// File: rtl/layer4_window_addr_gen.sv
// rtl/layer4_window_addr_gen.sv - 3x3 sliding-window tap counters for the layer-5 read side
// Purpose: walks kx (fastest), ky, ocol, orow over every window of the map.
// Ports:
//   in : clk, rst (async active-low), clear (restart at tap 0), advance (tap issued)
//   out: orow, ocol, ky, kx, window_last (ky=kx=K-1), frame_last (final tap of frame)
module layer4_window_addr_gen #(
  parameter int MAP_W = layer4_ctrl_pkg::MAP_W,
  parameter int MAP_H = layer4_ctrl_pkg::MAP_H,
  parameter int K     = layer4_ctrl_pkg::K,
  localparam int OR_W = $clog2(MAP_H - K + 1),
  localparam int OC_W = $clog2(MAP_W - K + 1),
  localparam int KW   = $clog2(K)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            advance,
  output logic [OR_W-1:0] orow,
  output logic [OC_W-1:0] ocol,
  output logic [KW-1:0]   ky,
  output logic [KW-1:0]   kx,
  output logic            window_last,
  output logic            frame_last
);
  logic [OR_W-1:0] orow_q, orow_d;
  logic [OC_W-1:0] ocol_q, ocol_d;
  logic [KW-1:0]   ky_q, ky_d, kx_q, kx_d;
  logic            kx_end, ky_end, ocol_end, orow_end;

  assign kx_end   = (kx_q == KW'(K - 1));
  assign ky_end   = (ky_q == KW'(K - 1));
  assign ocol_end = (ocol_q == OC_W'(MAP_W - K));
  assign orow_end = (orow_q == OR_W'(MAP_H - K));

  always_comb begin
    orow_d = orow_q;
    ocol_d = ocol_q;
    ky_d   = ky_q;
    kx_d   = kx_q;
    if (clear) begin
      orow_d = '0;
      ocol_d = '0;
      ky_d   = '0;
      kx_d   = '0;
    end else if (advance) begin
      // Odometer carry chain: kx -> ky -> ocol -> orow; wraps to tap 0 after the last window.
      if (!kx_end) begin
        kx_d = kx_q + 1'b1;
      end else begin
        kx_d = '0;
        if (!ky_end) begin
          ky_d = ky_q + 1'b1;
        end else begin
          ky_d = '0;
          if (!ocol_end) begin
            ocol_d = ocol_q + 1'b1;
          end else begin
            ocol_d = '0;
            orow_d = orow_end ? '0 : orow_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      orow_q <= '0;
      ocol_q <= '0;
      ky_q   <= '0;
      kx_q   <= '0;
    end else begin
      orow_q <= orow_d;
      ocol_q <= ocol_d;
      ky_q   <= ky_d;
      kx_q   <= kx_d;
    end
  end

  assign orow        = orow_q;
  assign ocol        = ocol_q;
  assign ky          = ky_q;
  assign kx          = kx_q;
  assign window_last = kx_end & ky_end;
  assign frame_last  = kx_end & ky_end & ocol_end & orow_end;
endmodule

// File: rtl/layer4_result_mem_ctrl.sv
// rtl/layer4_result_mem_ctrl.sv - layer-4 result SRAM sequencer (write stream in, 3x3 tap reads out)
// Purpose: frame FSM, write-side row/col counters and row-completion gating of window reads.
// Ports:
//   in : clk, rst (async active-low), start (frame pulse, honoured in IDLE)
//   bus: layer4_result_mem_ctrl_if.master (write strobe/addresses, read strobe/addresses, tap info)
//   out: frame_done (one cycle in DONE), busy (not IDLE), wr_overflow (sticky write-after-full)
module layer4_result_mem_ctrl #(
  parameter int MAP_W  = layer4_ctrl_pkg::MAP_W,
  parameter int MAP_H  = layer4_ctrl_pkg::MAP_H,
  parameter int K      = layer4_ctrl_pkg::K,
  parameter int ADDR_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  layer4_result_mem_ctrl_if.master  bus,
  output logic                      frame_done,
  output logic                      busy,
  output logic                      wr_overflow
);
  import layer4_ctrl_pkg::*;

  localparam int RW   = $clog2(MAP_H);
  localparam int CW   = $clog2(MAP_W);
  localparam int RDW  = $clog2(MAP_H + 1);
  localparam int NW   = RDW + 1;
  localparam int OR_W = $clog2(MAP_H - K + 1);
  localparam int OC_W = $clog2(MAP_W - K + 1);
  localparam int KW   = $clog2(K);

  state_e            state_q, state_d;
  logic [RW-1:0]     wr_row_q, wr_row_d;
  logic [CW-1:0]     wr_col_q, wr_col_d;
  logic [RDW-1:0]    rows_done_q, rows_done_d;
  logic              wr_full_q, wr_full_d;
  logic              wr_overflow_q, wr_overflow_d;
  logic [ADDR_W-1:0] rd_row_q, rd_row_d, rd_col_q, rd_col_d;

  logic              save_en, issue, clear, readable, win_last, frame_last;
  logic [OR_W-1:0]   orow;
  logic [OC_W-1:0]   ocol;
  logic [KW-1:0]     ky, kx;
  logic [NW-1:0]     need_rows;
  logic [ADDR_W-1:0] cur_row, cur_col;

  layer4_window_addr_gen #(.MAP_W(MAP_W), .MAP_H(MAP_H), .K(K)) u_win (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .advance    (issue),
    .orow       (orow),
    .ocol       (ocol),
    .ky         (ky),
    .kx         (kx),
    .window_last(win_last),
    .frame_last (frame_last)
  );

  // A window may be read once all K of its rows are completely written, so reads
  // never touch the row currently being filled.
  assign need_rows = NW'(orow) + NW'(K);
  assign readable  = (NW'(rows_done_q) >= need_rows);
  assign cur_row   = ADDR_W'(orow) + ADDR_W'(ky);
  assign cur_col   = ADDR_W'(ocol) + ADDR_W'(kx);
  assign clear     = (state_q == IDLE) & start;

  always_comb begin
    state_d       = state_q;
    wr_row_d      = wr_row_q;
    wr_col_d      = wr_col_q;
    rows_done_d   = rows_done_q;
    wr_full_d     = wr_full_q;
    wr_overflow_d = wr_overflow_q;
    rd_row_d      = rd_row_q;
    rd_col_d      = rd_col_q;
    save_en       = 1'b0;
    issue         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = RUN;
          wr_row_d      = '0;
          wr_col_d      = '0;
          rows_done_d   = '0;
          wr_full_d     = 1'b0;
          wr_overflow_d = 1'b0;
        end
      end
      RUN: begin
        save_en = bus.wr_valid & ~wr_full_q;
        issue   = bus.rd_ready & readable;
        if (bus.wr_valid & wr_full_q) wr_overflow_d = 1'b1;
        if (save_en) begin
          if (wr_col_q == CW'(MAP_W - 1)) begin
            wr_col_d    = '0;
            rows_done_d = rows_done_q + 1'b1;
            if (wr_row_q == RW'(MAP_H - 1)) begin
              wr_row_d  = '0;
              wr_full_d = 1'b1;
            end else begin
              wr_row_d = wr_row_q + 1'b1;
            end
          end else begin
            wr_col_d = wr_col_q + 1'b1;
          end
        end
        if (issue & frame_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Remember the issued address so the outputs hold it while no tap is issued.
    if (issue) begin
      rd_row_d = cur_row;
      rd_col_d = cur_col;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      wr_row_q      <= '0;
      wr_col_q      <= '0;
      rows_done_q   <= '0;
      wr_full_q     <= 1'b0;
      wr_overflow_q <= 1'b0;
      rd_row_q      <= '0;
      rd_col_q      <= '0;
    end else begin
      state_q       <= state_d;
      wr_row_q      <= wr_row_d;
      wr_col_q      <= wr_col_d;
      rows_done_q   <= rows_done_d;
      wr_full_q     <= wr_full_d;
      wr_overflow_q <= wr_overflow_d;
      rd_row_q      <= rd_row_d;
      rd_col_q      <= rd_col_d;
    end
  end

  assign bus.save_enable               = save_en;
  assign bus.save_row_addr             = ADDR_W'(wr_row_q);
  assign bus.save_col_addr             = ADDR_W'(wr_col_q);
  assign bus.layer4_result_read_signal = issue;
  assign bus.tap_valid                 = issue;
  assign bus.read_row_addr             = issue ? cur_row : rd_row_q;
  assign bus.read_col_addr             = issue ? cur_col : rd_col_q;
  assign bus.tap_idx                   = 4'(ky) * 4'(K) + 4'(kx);
  assign bus.window_last               = issue & win_last;
  assign frame_done                    = (state_q == DONE);
  assign busy                          = (state_q != IDLE);
  assign wr_overflow                   = wr_overflow_q;
endmodule

// File: tb/tb_layer4_result_mem_ctrl.sv
// tb/tb_layer4_result_mem_ctrl.sv - directed self-checking bench for layer4_result_mem_ctrl
module tb_layer4_result_mem_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic frame_done, busy, wr_overflow;
  int   n_checks = 0;
  int   n_errors = 0;

  layer4_result_mem_ctrl_if #(.ADDR_W(16)) bus ();

  layer4_result_mem_ctrl #(.MAP_W(12), .MAP_H(12), .K(3), .ADDR_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .frame_done (frame_done),
    .busy       (busy),
    .wr_overflow(wr_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference tap order: t = ((orow*10 + ocol)*3 + ky)*3 + kx.
  function automatic logic [63:0] m_row(input int t);
    return 64'((t / 9) / 10 + (t % 9) / 3);
  endfunction
  function automatic logic [63:0] m_col(input int t);
    return 64'((t / 9) % 10 + (t % 9) % 3);
  endfunction

  task automatic check_tap(input int t);
    check($sformatf("tap_valid[%0d]", t), 64'(bus.tap_valid), 64'(1));
    check($sformatf("rd_row[%0d]", t), 64'(bus.read_row_addr), m_row(t));
    check($sformatf("rd_col[%0d]", t), 64'(bus.read_col_addr), m_col(t));
    check($sformatf("tap_idx[%0d]", t), 64'(bus.tap_idx), 64'(t % 9));
    check($sformatf("win_last[%0d]", t), 64'(bus.window_last), 64'((t % 9) == 8));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({bus.save_enable, bus.save_row_addr, bus.save_col_addr,
                              bus.layer4_result_read_signal, bus.tap_valid, bus.tap_idx,
                              bus.window_last, frame_done, busy, wr_overflow}), 64'(0));
    check({tag, "_rdaddr"}, 64'({bus.read_row_addr, bus.read_col_addr}), 64'(0));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int taps;
    bit done_seen, hit, found;

    rst = 1'b0; start = 1'b0; bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", 64'(busy), 64'(0));

    // Write sweep with reads held off, then one write past full.
    pulse_start();
    check("run_busy", 64'(busy), 64'(1));
    for (int i = 0; i < 144; i++) begin
      bus.wr_valid = 1'b1; #1;
      check($sformatf("save_en[%0d]", i), 64'(bus.save_enable), 64'(1));
      check($sformatf("save_row[%0d]", i), 64'(bus.save_row_addr), 64'(i / 12));
      check($sformatf("save_col[%0d]", i), 64'(bus.save_col_addr), 64'(i % 12));
      check($sformatf("no_read[%0d]", i), 64'(bus.layer4_result_read_signal), 64'(0));
      @(posedge clk); #1;
    end
    #1;
    check("save_en_full", 64'(bus.save_enable), 64'(0));
    check("ovf_before", 64'(wr_overflow), 64'(0));
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
    check("ovf_sticky", 64'(wr_overflow), 64'(1));

    // Read the fully written map, stalling 5 cycles after tap 4 of window 0.
    bus.rd_ready = 1'b1;
    for (int t = 0; t < 900; t++) begin
      if (t == 5) begin
        bus.rd_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          #1;
          check($sformatf("stall_valid[%0d]", s), 64'(bus.tap_valid), 64'(0));
          check($sformatf("stall_oeb[%0d]", s), 64'(bus.layer4_result_read_signal), 64'(0));
          check($sformatf("stall_addr[%0d]", s),
                64'({bus.read_row_addr, bus.read_col_addr}), 64'({16'd1, 16'd1}));
          @(posedge clk); #1;
        end
        bus.rd_ready = 1'b1;
      end
      #1;
      check_tap(t);
      @(posedge clk); #1;
    end
    #1;
    check("b_frame_done", 64'(frame_done), 64'(1));
    check("b_no_tap", 64'(bus.tap_valid), 64'(0));
    check("b_ovf_kept", 64'(wr_overflow), 64'(1));
    @(posedge clk); #1;
    check("b_done_pulse", 64'(frame_done), 64'(0));
    check("b_busy_low", 64'(busy), 64'(0));

    // Concurrent write and read frame; reads gated until row 2 is complete.
    bus.rd_ready = 1'b1;
    pulse_start();
    taps = 0; done_seen = 0;
    for (int c = 0; c < 3000 && !done_seen; c++) begin
      bus.wr_valid = (c < 144); #1;
      if (c == 0) check("c_ovf_cleared", 64'(wr_overflow), 64'(0));
      if (c <= 35) check($sformatf("gate[%0d]", c), 64'(bus.layer4_result_read_signal), 64'(0));
      if (c == 36) check("gate_open", 64'(bus.tap_valid), 64'(1));
      if (bus.tap_valid) begin
        if (taps < 900) check_tap(taps);
        taps++;
      end
      if (frame_done) begin
        done_seen = 1;
        check("c_done_after_last", 64'(taps), 64'(900));
      end
      @(posedge clk); #1;
    end
    bus.wr_valid = 1'b0;
    check("c_done_seen", 64'(done_seen), 64'(1));
    check("c_tap_count", 64'(taps), 64'(900));
    #1;
    check("c_done_pulse", 64'(frame_done), 64'(0));
    check("c_busy_low", 64'(busy), 64'(0));
    check("c_no_ovf", 64'(wr_overflow), 64'(0));

    // Asynchronous reset at tap 400, then a clean restart.
    pulse_start();
    taps = 0; hit = 0;
    for (int c = 0; c < 3000 && !hit; c++) begin
      bus.wr_valid = (c < 144); #1;
      if (bus.tap_valid) begin
        if (taps == 400) begin
          hit = 1;
          rst = 1'b0; #1;
          check_all_zero("midreset");
        end
        taps++;
      end
      if (!hit) begin
        @(posedge clk); #1;
      end
    end
    check("reach_tap400", 64'(hit), 64'(1));
    bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_reset_busy", 64'(busy), 64'(0));
    check("post_reset_tap", 64'(bus.tap_valid), 64'(0));
    bus.rd_ready = 1'b1;
    pulse_start();
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      bus.wr_valid = 1'b1; #1;
      if (bus.tap_valid) begin
        found = 1;
        check("restart_latency", 64'(c), 64'(36));
        check("restart_addr", 64'({bus.read_row_addr, bus.read_col_addr}), 64'(0));
        check("restart_idx", 64'(bus.tap_idx), 64'(0));
      end
      @(posedge clk); #1;
    end
    check("restart_seen", 64'(found), 64'(1));
    bus.wr_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
